bbox_raster_engine: RTL and testbench

Parametrised successor to the single-channel bounding-box pixel generator. Reads a scene descriptor (shape count plus per-shape box and colour) from byte-wide external memory over a req/ack bus. For every pixel of a 2^COORD_W x 2^COORD_W frame it finds the topmost covering shape and writes that colour, or BG_COLOUR, to the framebuffer region. Sits between the host start/status pins and the external memory arbiter.

---
 rtl/bbox_raster_engine.sv | 216 +++++++++++++++++++++
 tb/tb_bbox_raster_engine.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_raster_engine.sv
`timescale 1ns/1ps
// Bounding-box rasteriser: reads a scene of coloured boxes over a byte-wide req/ack bus and paints
// every pixel with its topmost covering box colour. Optional macro FRAME_LOOP_EN renders continuously.
module bbox_raster_engine #(
    parameter int                COORD_W    = 7,
    parameter int                ADDR_W     = 24,
    parameter int                BPP_BYTES  = 3,
    parameter logic [ADDR_W-1:0] FB_BASE    = 24'h800000,
    parameter logic [ADDR_W-1:0] SCENE_BASE = '0,
    parameter logic [31:0]       BG_COLOUR  = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [7:0]         mem_wdata,
    input  logic [7:0]         mem_rdata,
    input  logic               mem_ack,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y
);
    localparam int         PIX_W    = 2 * COORD_W;
    localparam int         REC      = 4 + BPP_BYTES;
    localparam logic [1:0] LAST_COL = 2'(BPP_BYTES - 1);

    typedef enum logic [2:0] {IDLE, RD_N, RD_BOX, CHECK, RD_COL, WR_PIX, NEXT_PIX, DONE} state_e;

    state_e              state_q, state_d;
    logic                req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          n_q, n_d, k_q, k_d;
    logic [1:0]          beat_q, beat_d;
    logic [COORD_W-1:0]  xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
    logic [31:0]         colour_q, colour_d;
    logic [PIX_W-1:0]    pix_q, pix_d;

    logic [ADDR_W-1:0]   rec_addr, bus_addr;
    logic                bus_state, acked, hit;

    assign pix_x     = pix_q[COORD_W-1:0];
    assign pix_y     = pix_q[PIX_W-1:COORD_W];
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = (state_q == DONE);
`ifdef FRAME_LOOP_EN
    assign busy      = (state_q != IDLE);
`else
    assign busy      = (state_q != IDLE) && (state_q != DONE);
`endif

    // Record of shape k; k_q is never 0 while this address is used.
    assign rec_addr  = SCENE_BASE + ADDR_W'(1) + (ADDR_W'(k_q) - ADDR_W'(1)) * ADDR_W'(REC);
    assign bus_state = (state_q == RD_N) || (state_q == RD_BOX) || (state_q == RD_COL) || (state_q == WR_PIX);
    assign acked     = req_q && mem_ack;
    assign hit       = (xmin_q <= pix_x) && (pix_x <= xmax_q) && (ymin_q <= pix_y) && (pix_y <= ymax_q);

    always_comb begin
        bus_addr = FB_BASE + ADDR_W'(pix_q) * ADDR_W'(BPP_BYTES) + ADDR_W'(beat_q);
        case (state_q)
            RD_N:    bus_addr = SCENE_BASE;
            RD_BOX:  bus_addr = rec_addr + ADDR_W'(beat_q);
            RD_COL:  bus_addr = rec_addr + ADDR_W'(4) + ADDR_W'(beat_q);
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every _d takes its _q value first so no path through this block can infer a latch.
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        n_d      = n_q;
        k_d      = k_q;
        beat_d   = beat_q;
        xmin_d   = xmin_q;
        xmax_d   = xmax_q;
        ymin_d   = ymin_q;
        ymax_d   = ymax_q;
        colour_d = colour_q;
        pix_d    = pix_q;

        // Launch a transaction whenever a bus state has no request open; the cycle after an ack
        // always has req low, giving the mandatory one-cycle gap.
        if (bus_state && !req_q) begin
            req_d   = 1'b1;
            we_d    = (state_q == WR_PIX);
            addr_d  = bus_addr;
            wdata_d = (state_q == WR_PIX) ? colour_q[{beat_q, 3'b000} +: 8] : 8'h00;
        end
        if (acked) begin
            req_d = 1'b0;
            we_d  = 1'b0;
        end

        case (state_q)
            IDLE: if (start) begin
                state_d = RD_N;
                pix_d   = '0;
                beat_d  = '0;
            end
            RD_N: if (acked) begin
                n_d    = mem_rdata;
                k_d    = mem_rdata;
                beat_d = '0;
                if (mem_rdata == 8'd0) begin
                    colour_d = BG_COLOUR;
                    state_d  = WR_PIX;
                end else begin
                    state_d  = RD_BOX;
                end
            end
            RD_BOX: if (acked) begin
                case (beat_q)
                    2'd0:    xmin_d = mem_rdata[COORD_W-1:0];
                    2'd1:    xmax_d = mem_rdata[COORD_W-1:0];
                    2'd2:    ymin_d = mem_rdata[COORD_W-1:0];
                    default: ymax_d = mem_rdata[COORD_W-1:0];
                endcase
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) state_d = CHECK;
            end
            CHECK: begin
                beat_d = '0;
                if (hit) begin
                    state_d = RD_COL;
                end else if (k_q == 8'd1) begin
                    colour_d = BG_COLOUR;
                    state_d  = WR_PIX;
                end else begin
                    k_d     = k_q - 8'd1;
                    state_d = RD_BOX;
                end
            end
            RD_COL: if (acked) begin
                colour_d[{beat_q, 3'b000} +: 8] = mem_rdata;
                beat_d = beat_q + 2'd1;
                if (beat_q == LAST_COL) begin
                    beat_d  = '0;
                    state_d = WR_PIX;
                end
            end
            WR_PIX: if (acked) begin
                beat_d = beat_q + 2'd1;
                if (beat_q == LAST_COL) begin
                    beat_d  = '0;
                    state_d = NEXT_PIX;
                end
            end
            NEXT_PIX: begin
                pix_d = pix_q + PIX_W'(1);
                k_d   = n_q;
                if (&pix_q) begin
                    state_d = DONE;
                end else if (n_q == 8'd0) begin
                    colour_d = BG_COLOUR;
                    state_d  = WR_PIX;
                end else begin
                    state_d  = RD_BOX;
                end
            end
            DONE: begin
`ifdef FRAME_LOOP_EN
                state_d = RD_N;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            n_q      <= '0;
            k_q      <= '0;
            beat_q   <= '0;
            xmin_q   <= '0;
            xmax_q   <= '0;
            ymin_q   <= '0;
            ymax_q   <= '0;
            colour_q <= '0;
            pix_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            n_q      <= n_d;
            k_q      <= k_d;
            beat_q   <= beat_d;
            xmin_q   <= xmin_d;
            xmax_q   <= xmax_d;
            ymin_q   <= ymin_d;
            ymax_q   <= ymax_d;
            colour_q <= colour_d;
            pix_q    <= pix_d;
        end
    end

endmodule

// File: tb/tb_bbox_raster_engine.sv
`timescale 1ns/1ps
// Self-checking bench for bbox_raster_engine: a memory responder logs every bus transaction and
// each frame's log is compared with the transaction list derived from the scene rules.
module tb_bbox_raster_engine;
    localparam int          CW   = 2;
    localparam int          AW   = 24;
    localparam int          BPP  = 3;
    localparam int          REC  = 4 + BPP;
    localparam int          SIDE = 1 << CW;
    localparam int          NPIX = SIDE * SIDE;
    localparam logic [23:0] FB   = 24'h800000;

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n, start, busy, done;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata;
    logic [CW-1:0] pix_x, pix_y;

    logic [7:0] scene [0:255];
    txn_t       exp_q[$];
    txn_t       act_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         delay_mode = 0;
    bit         stray_en = 1'b0;

    always #5 clk = ~clk;

    bbox_raster_engine #(
        .COORD_W(CW), .ADDR_W(AW), .BPP_BYTES(BPP),
        .FB_BASE(FB), .SCENE_BASE(24'h0), .BG_COLOUR(32'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pix_x(pix_x), .pix_y(pix_y)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic txn_t mk(input logic we, input int addr, input logic [7:0] data);
        txn_t t;
        t.we   = we;
        t.addr = 24'(addr);
        t.data = data;
        return t;
    endfunction

    function automatic int pick_delay();
        case (delay_mode)
            0:       return 0;
            1:       return int'($urandom_range(0, 3));
            default: return 5;
        endcase
    endfunction

    // Reference: for each pixel, scan shapes from the top, reading each box until one covers it.
    function automatic void build_expected();
        int n;
        exp_q.delete();
        exp_q.push_back(mk(1'b0, 0, 8'h00));
        n = int'(scene[0]);
        for (int p = 0; p < NPIX; p++) begin
            int x = p % SIDE;
            int y = p / SIDE;
            logic [7:0] col [0:BPP-1];
            for (int b = 0; b < BPP; b++) col[b] = 8'h00;
            for (int k = n; k >= 1; k--) begin
                int base = 1 + (k - 1) * REC;
                int x0 = int'(scene[base]) % SIDE;
                int x1 = int'(scene[base + 1]) % SIDE;
                int y0 = int'(scene[base + 2]) % SIDE;
                int y1 = int'(scene[base + 3]) % SIDE;
                for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, base + i, 8'h00));
                if (x >= x0 && x <= x1 && y >= y0 && y <= y1) begin
                    for (int b = 0; b < BPP; b++) begin
                        exp_q.push_back(mk(1'b0, base + 4 + b, 8'h00));
                        col[b] = scene[base + 4 + b];
                    end
                    break;
                end
            end
            for (int b = 0; b < BPP; b++) exp_q.push_back(mk(1'b1, int'(FB) + p * BPP + b, col[b]));
        end
    endfunction

    // Memory responder: optional wait states, bus-stability and req-gap checks, stray acks.
    initial begin
        bit          in_txn = 1'b0;
        bit          real_ack = 1'b0;
        int          wait_c = 0;
        txn_t        cur;
        logic [32:0] raw;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ack  = 1'b0;
                in_txn   = 1'b0;
                real_ack = 1'b0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                if (real_ack) begin
                    check("req_gap_after_ack", mem_req, 1'b0);
                    real_ack = 1'b0;
                end
            end else if (mem_req) begin
                if (!in_txn) begin
                    in_txn   = 1'b1;
                    raw      = {mem_we, mem_addr, mem_wdata};
                    cur.we   = mem_we;
                    cur.addr = mem_addr;
                    cur.data = mem_we ? mem_wdata : 8'h00;
                    wait_c   = pick_delay();
                end else begin
                    check("bus_stable_until_ack", {mem_we, mem_addr, mem_wdata}, raw);
                end
                if (wait_c == 0) begin
                    mem_ack   = 1'b1;
                    real_ack  = 1'b1;
                    in_txn    = 1'b0;
                    mem_rdata = (!cur.we && cur.addr < 24'd256) ? scene[cur.addr[7:0]] : 8'h5A;
                    act_q.push_back(cur);
                end else begin
                    wait_c--;
                end
            end else if (stray_en && $urandom_range(0, 3) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'hEE;
            end
        end
    end

    task automatic clear_scene();
        for (int i = 0; i < 256; i++) scene[i] = 8'h00;
    endtask

    task automatic set_shape(input int k, input logic [7:0] x0, input logic [7:0] x1,
                             input logic [7:0] y0, input logic [7:0] y1, input logic [31:0] col);
        int base = 1 + (k - 1) * REC;
        scene[base]     = x0;
        scene[base + 1] = x1;
        scene[base + 2] = y0;
        scene[base + 3] = y1;
        for (int b = 0; b < BPP; b++) scene[base + 4 + b] = col[8*b +: 8];
    endtask

    task automatic run_frame(input string tag);
        int cyc = 0;
        bit got_done = 1'b0;
        bit busy_ok = 1'b1;
        act_q.delete();
        build_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1'b1);
        while (!got_done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 30);
            if (done === 1'b1) got_done = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, got_done, 1'b1);
        check({tag, "_busy_held"}, busy_ok, 1'b1);
        check({tag, "_busy_low_at_done"}, busy, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_one_cycle"}, done, 1'b0);
        check({tag, "_start_in_done_ignored"}, busy, 1'b0);
        repeat (3) @(negedge clk);
        check({tag, "_idle_quiet"}, {busy, mem_req, mem_we}, 3'b000);
        check({tag, "_pix_wrapped"}, {pix_y, pix_x}, '0);
        check({tag, "_txn_count"}, act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_txn%0d", tag, i), act_q[i], exp_q[i]);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  cyc;
        bit  hit7;
        rst_n = 1'b0;
        start = 1'b0;
        clear_scene();
        repeat (3) @(negedge clk);
        check("reset_ctrl", {busy, done, mem_req, mem_we}, 4'b0000);
        check("reset_bus", {mem_addr, mem_wdata}, '0);
        check("reset_pix", {pix_y, pix_x}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {busy, mem_req}, 2'b00);

        // Empty scene: whole frame background.
        run_frame("empty");

        // Single box in the middle.
        clear_scene();
        scene[0] = 8'd1;
        set_shape(1, 8'd1, 8'd2, 8'd1, 8'd2, 32'h112233);
        run_frame("single");

        // Overlap: shape 2 sits on top of full-frame shape 1.
        clear_scene();
        scene[0] = 8'd2;
        set_shape(1, 8'd0, 8'd3, 8'd0, 8'd3, 32'h0000FF);
        set_shape(2, 8'd1, 8'd1, 8'd1, 8'd1, 32'h00FF00);
        run_frame("overlap");

        // Degenerate box never covers anything.
        clear_scene();
        scene[0] = 8'd1;
        set_shape(1, 8'd3, 8'd1, 8'd0, 8'd3, 32'hCCBBAA);
        run_frame("degenerate");

        // Slow memory plus stray acks on the overlap scene.
        clear_scene();
        scene[0] = 8'd2;
        set_shape(1, 8'd0, 8'd3, 8'd0, 8'd3, 32'h0000FF);
        set_shape(2, 8'd1, 8'd1, 8'd1, 8'd1, 32'h00FF00);
        delay_mode = 2;
        stray_en   = 1'b1;
        run_frame("slow");

        // Random scenes with random wait states; upper coordinate bits are random too.
        delay_mode = 1;
        for (int r = 0; r < 4; r++) begin
            clear_scene();
            scene[0] = 8'($urandom_range(0, 5));
            for (int k = 1; k <= int'(scene[0]); k++)
                set_shape(k, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), $urandom);
            run_frame($sformatf("rand%0d", r));
        end

        // Reset while a request is open on pixel 7, then a clean frame.
        clear_scene();
        scene[0] = 8'd2;
        set_shape(1, 8'd0, 8'd2, 8'd1, 8'd3, 32'h445566);
        set_shape(2, 8'd3, 8'd3, 8'd0, 8'd3, 32'h778899);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc  = 0;
        hit7 = 1'b0;
        while (!hit7 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if ({pix_y, pix_x} == 4'd7 && mem_req === 1'b1) hit7 = 1'b1;
        end
        check("rst_reached_pixel7", hit7, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_async_req_busy", {mem_req, busy, done}, 3'b000);
        check("rst_async_pix", {pix_y, pix_x}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_no_restart", {busy, mem_req}, 2'b00);
        run_frame("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
